// File: rtl/ones_comp_serial_sub.sv
// Bit-serial one's-complement adder/subtractor: an LSB-first add pass, then an end-around-carry pass.
// Latency is fixed at 2*WIDTH+1 edges from the start sample to done. start is ignored while busy.
module ones_comp_serial_sub #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             sub,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] Y,
   output logic             zero,
   output logic             neg,
   output logic             ovf
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {IDLE, ADD, WRAP, DONE} state_t;

   state_t state, nstate;

   logic [WIDTH-1:0] sa, sb, r;
   logic [CW-1:0]    cnt;
   logic             carry, eac, ovf_p;
   logic             last;
   logic             op_a, op_b, cin, sbit, cout;

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= nstate;
   end

   always_comb begin
      nstate = state;
      busy   = 1'b0;
      last   = (cnt == LAST);
      case (state)
         IDLE: if (start) nstate = ADD;
         ADD: begin
            busy = 1'b1;
            if (last) nstate = WRAP;
         end
         WRAP: begin
            busy = 1'b1;
            if (last) nstate = DONE;
         end
         DONE: begin
            busy   = 1'b1;
            nstate = IDLE;
         end
         default: nstate = IDLE;
      endcase
   end

   // Shared full adder: the add pass uses SA/SB, the wrap pass re-adds the carry into R.
   always_comb begin
      op_a = (state == ADD) ? sa[cnt] : r[cnt];
      op_b = (state == ADD) ? sb[cnt] : 1'b0;
      cin  = (state == WRAP && cnt == '0) ? eac : carry;
      sbit = op_a ^ op_b ^ cin;
      cout = (op_a & op_b) | (cin & (op_a ^ op_b));
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sa    <= '0;
         sb    <= '0;
         r     <= '0;
         cnt   <= '0;
         carry <= 1'b0;
         eac   <= 1'b0;
         ovf_p <= 1'b0;
         Y     <= '0;
         done  <= 1'b0;
         zero  <= 1'b1;
         neg   <= 1'b0;
         ovf   <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  sa    <= A;
                  sb    <= sub ? ~B : B;
                  carry <= 1'b0;
                  cnt   <= '0;
               end
            end
            ADD: begin
               r[cnt] <= sbit;
               if (last) begin
                  eac   <= cout;
                  carry <= 1'b0;
                  ovf_p <= (sa[WIDTH-1] == sb[WIDTH-1]) && (sbit != sa[WIDTH-1]);
                  cnt   <= '0;
               end else begin
                  carry <= cout;
                  cnt   <= cnt + 1'b1;
               end
            end
            WRAP: begin
               r[cnt] <= sbit;
               carry  <= cout;
               if (last) cnt <= '0;
               else      cnt <= cnt + 1'b1;
            end
            DONE: begin
               Y    <= r;
               zero <= (r == '0) || (r == '1);
               neg  <= r[WIDTH-1] && (r != '1);
               ovf  <= ovf_p;
               done <= 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_ones_comp_serial_sub.sv
// Randomized and directed bench for ones_comp_serial_sub against an arithmetic reference model.
module tb_ones_comp_serial_sub;

   localparam int W = 4;

   logic         clk = 1'b0;
   logic         rst, start, sub;
   logic [W-1:0] A, B;
   logic         busy, done, zero, neg, ovf;
   logic [W-1:0] Y;

   ones_comp_serial_sub #(.WIDTH(W)) dut (
      .clk(clk), .rst(rst), .start(start), .sub(sub), .A(A), .B(B),
      .busy(busy), .done(done), .Y(Y), .zero(zero), .neg(neg), .ovf(ovf)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [W-1:0] y;
      logic         zero;
      logic         neg;
      logic         ovf;
   } res_t;

   int n_cmp  = 0;
   int n_fail = 0;
   bit chk_en = 1'b0;

   // One's-complement arithmetic: wide add, then fold the carry back in.
   function automatic res_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
      logic [W-1:0] bb;
      logic [W:0]   t;
      res_t         res;
      bb       = s ? ~b : b;
      t        = {1'b0, a} + {1'b0, bb};
      res.y    = t[W-1:0] + {{(W-1){1'b0}}, t[W]};
      res.ovf  = (a[W-1] == bb[W-1]) && (t[W-1] != a[W-1]);
      res.zero = (res.y == '0) || (res.y == '1);
      res.neg  = res.y[W-1] && (res.y != '1);
      return res;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Transaction-level timing model: busy for 2*W+1 edges, result published with done.
   logic m_busy, m_done;
   int   m_cnt;
   res_t m_res, m_pend;

   always @(posedge clk) begin
      if (rst) begin
         m_busy <= 1'b0;
         m_done <= 1'b0;
         m_cnt  <= 0;
         m_res  <= '{y: '0, zero: 1'b1, neg: 1'b0, ovf: 1'b0};
      end else begin
         m_done <= 1'b0;
         if (!m_busy) begin
            if (start) begin
               m_busy <= 1'b1;
               m_cnt  <= 0;
               m_pend <= model(A, B, sub);
            end
         end else if (m_cnt == 2 * W) begin
            m_busy <= 1'b0;
            m_done <= 1'b1;
            m_res  <= m_pend;
         end else begin
            m_cnt <= m_cnt + 1;
         end
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         check("done",  {31'b0, done}, {31'b0, m_done});
         check("busy",  {31'b0, busy}, {31'b0, m_busy});
         check("Y",     {{(32-W){1'b0}}, Y}, {{(32-W){1'b0}}, m_res.y});
         check("flags", {29'b0, zero, neg, ovf}, {29'b0, m_res.zero, m_res.neg, m_res.ovf});
      end
   end

   task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
      @(posedge clk);
      #2;
      A = a; B = b; sub = s; start = 1'b1;
   endtask

   // Waits the start-sampling edge, scrambles the inputs, then counts edges until done.
   task automatic complete(output int n);
      bit found;
      @(posedge clk);
      #2;
      start = 1'b0;
      A = W'($urandom); B = W'($urandom); sub = 1'($urandom);
      n = 0;
      found = 1'b0;
      while (n < 40 && !found) begin
         @(posedge clk);
         n++;
         @(negedge clk);
         if (done) found = 1'b1;
      end
      if (!found) begin
         n_cmp++;
         n_fail++;
         $display("FAIL timeout: no done within 40 edges");
      end
   endtask

   task automatic directed(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                           input logic [W-1:0] ey, input logic ez, input logic en, input logic eo,
                           input string name);
      int n;
      launch(a, b, s);
      complete(n);
      check({name, "_lat"}, n, 9);
      check({name, "_y"}, {{(32-W){1'b0}}, Y}, {{(32-W){1'b0}}, ey});
      check({name, "_flags"}, {29'b0, zero, neg, ovf}, {29'b0, ez, en, eo});
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int n, nd, p, gap;
      bit found;
      rst = 1'b1; start = 1'b0; sub = 1'b0; A = '0; B = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk_en = 1'b1;
      check("rst_busy", {31'b0, busy}, 32'd0);
      check("rst_done", {31'b0, done}, 32'd0);
      check("rst_y",    {{(32-W){1'b0}}, Y}, 32'd0);
      check("rst_zero", {31'b0, zero}, 32'd1);

      // First start coincides with reset release.
      @(posedge clk);
      #2;
      rst = 1'b0; A = 4'b0101; B = 4'b0011; sub = 1'b1; start = 1'b1;
      complete(n);
      check("first_lat", n, 9);
      check("first_y", {{(32-W){1'b0}}, Y}, 32'b0010);

      directed(4'b0101, 4'b0011, 1'b1, 4'b0010, 1'b0, 1'b0, 1'b0, "sub_eac1");
      directed(4'b0011, 4'b0101, 1'b1, 4'b1101, 1'b0, 1'b1, 1'b0, "sub_eac0");
      directed(4'b0101, 4'b0101, 1'b1, 4'b1111, 1'b1, 1'b0, 1'b0, "neg_zero");
      directed(4'b0110, 4'b0011, 1'b0, 4'b1001, 1'b0, 1'b1, 1'b1, "add_ovf");
      directed(4'b1110, 4'b1101, 1'b0, 4'b1100, 1'b0, 1'b1, 1'b0, "add_negs");

      // start pulsed mid-operation must be dropped.
      launch(4'b0101, 4'b0011, 1'b1);
      @(posedge clk);
      #2 start = 1'b0;
      repeat (2) @(posedge clk);
      #2;
      A = 4'b0110; B = 4'b0011; sub = 1'b0; start = 1'b1;
      @(posedge clk);
      #2 start = 1'b0;
      nd = 0;
      repeat (20) begin
         @(negedge clk);
         if (done) nd++;
      end
      check("busy_start_dones", nd, 1);
      check("busy_start_y", {{(32-W){1'b0}}, Y}, 32'b0010);

      // start held high: back-to-back operations, done period 2*W+2.
      launch(4'b1110, 4'b1101, 1'b0);
      found = 1'b0;
      for (int i = 0; i < 40 && !found; i++) begin
         @(negedge clk);
         if (done) found = 1'b1;
      end
      check("held_first_done", {31'b0, found}, 32'd1);
      p = 0;
      found = 1'b0;
      while (p < 40 && !found) begin
         @(negedge clk);
         p++;
         if (done) found = 1'b1;
      end
      check("held_period", p, 10);
      check("held_y", {{(32-W){1'b0}}, Y}, 32'b1100);
      @(posedge clk);
      #2 start = 1'b0;
      repeat (14) @(posedge clk);

      // Reset during the wrap pass aborts without a done pulse.
      launch(4'b0110, 4'b0011, 1'b0);
      @(posedge clk);
      #2 start = 1'b0;
      repeat (6) @(posedge clk);
      #2 rst = 1'b1;
      @(posedge clk);
      #2 rst = 1'b0;
      @(negedge clk);
      check("abort_busy", {31'b0, busy}, 32'd0);
      check("abort_y",    {{(32-W){1'b0}}, Y}, 32'd0);
      check("abort_zero", {31'b0, zero}, 32'd1);
      nd = 0;
      repeat (15) begin
         @(negedge clk);
         if (done) nd++;
      end
      check("abort_no_done", nd, 0);
      directed(4'b0101, 4'b0011, 1'b1, 4'b0010, 1'b0, 1'b0, 1'b0, "after_abort");

      // Randomized operations with idle gaps; the model checks every cycle.
      for (int k = 0; k < 150; k++) begin
         launch(W'($urandom), W'($urandom), 1'($urandom));
         complete(n);
         check("rand_lat", n, 9);
         gap = $urandom_range(0, 3);
         repeat (gap) @(posedge clk);
      end

      repeat (3) @(posedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
